branch_pht: RTL

Parametrised pattern history table of saturating counters for the RISC-V core's fetch-stage branch predictor. Provides a combinational taken/not-taken prediction for the fetch PC. Updates one counter per cycle when a branch resolves in execute. Optionally hashes the PC with a global history register (gshare mode), and keeps branch and mispredict counts for CSR readout.

---
 rtl/branch_pht.sv | 98 +++++++++
 1 files changed

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - pattern history table of saturating counters with optional gshare hashing
module branch_pht #(
    parameter int CTR_WIDTH = 2,
    parameter int ENTRIES   = 64,
    parameter int GHIST_W   = 0,
    parameter int INIT      = 2**(CTR_WIDTH-1)-1,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int GH_W     = (GHIST_W > 0) ? GHIST_W : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pred_pc,
    output logic                 pred_taken,
    output logic [IDX_W-1:0]     pred_idx,
    input  logic                 upd_valid,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_pred,
    output logic [GH_W-1:0]      ghist,
    output logic [31:0]          num_branches,
    output logic [31:0]          num_mispredicts
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT);

    logic [CTR_WIDTH-1:0] r_table [ENTRIES];
    logic [31:0]          r_num_branches;
    logic [31:0]          r_num_mispredicts;
    logic [IDX_W-1:0]     w_base;
    logic [IDX_W-1:0]     w_idx;
    logic [GH_W-1:0]      w_ghr;
    logic [CTR_WIDTH-1:0] w_cur;
    logic                 w_unused_pc;

    assign w_base      = pred_pc[IDX_W+1:2];
    assign w_unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    generate
        if (GHIST_W == 0) begin : g_bimodal
            assign w_ghr = '0;
            assign w_idx = w_base;
        end else begin : g_gshare
            logic [GH_W-1:0] r_ghr;
            // History is trained only from resolved branches, newest outcome in the LSB.
            if (GHIST_W == 1) begin : g_ghr1
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        r_ghr <= '0;
                    else if (upd_valid)
                        r_ghr <= upd_taken;
                end
            end else begin : g_ghrn
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        r_ghr <= '0;
                    else if (upd_valid)
                        r_ghr <= {r_ghr[GH_W-2:0], upd_taken};
                end
            end
            assign w_ghr = r_ghr;
            assign w_idx = w_base ^ IDX_W'(r_ghr);
        end
    endgenerate

    assign w_cur = r_table[upd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_table[i] <= CTR_INIT;
        end else if (upd_valid) begin
            if (upd_taken && (w_cur != CTR_MAX))
                r_table[upd_idx] <= w_cur + 1'b1;
            else if (!upd_taken && (w_cur != '0))
                r_table[upd_idx] <= w_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_branches    <= '0;
            r_num_mispredicts <= '0;
        end else if (upd_valid) begin
            r_num_branches <= r_num_branches + 32'd1;
            if (upd_pred != upd_taken)
                r_num_mispredicts <= r_num_mispredicts + 32'd1;
        end
    end

    // Read port has no bypass: a same-cycle update is seen on the next cycle.
    assign pred_idx        = w_idx;
    assign pred_taken      = r_table[w_idx][CTR_WIDTH-1];
    assign ghist           = w_ghr;
    assign num_branches    = r_num_branches;
    assign num_mispredicts = r_num_mispredicts;

endmodule
